// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, issues pointers to inst_fetch over the
// enable/busy handshake and presents each returned instruction to decode.
module fetch_sequencer #(
    parameter int                   WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
    parameter logic [WORD_SIZE-1:0] PC_STEP   = 1,
    parameter int                   CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    output logic [WORD_SIZE-1:0] fetch_ptr,
    output logic                 fetch_enable,
    input  logic                 fetch_busy,
    input  logic [WORD_SIZE-1:0] fetch_inst,
    output logic [WORD_SIZE-1:0] inst_out,
    output logic [WORD_SIZE-1:0] inst_pc,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic [CNT_W-1:0]     fetch_count,
    output logic [1:0]           state_dbg
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]           state;
    logic [WORD_SIZE-1:0] pc;
    logic                 squash;
    logic [1:0]           resume;

    assign fetch_ptr    = pc;
    assign fetch_enable = (state == ISSUE);
    assign inst_valid   = (state == HOLD);
    assign state_dbg    = state;
    // Where to go once the current transaction is finished.
    assign resume       = run ? ISSUE : IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            squash      <= 1'b0;
            inst_out    <= '0;
            inst_pc     <= '0;
            fetch_count <= '0;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_pc;
            end
            case (state)
                IDLE: begin
                    if (!redirect_valid && run) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A redirect while the fetch is accepted marks it for discard.
                    if (fetch_busy) begin
                        state  <= WAIT;
                        squash <= redirect_valid;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        if (fetch_busy) begin
                            squash <= 1'b1;
                        end else begin
                            squash <= 1'b0;
                            state  <= resume;
                        end
                    end else if (!fetch_busy) begin
                        if (squash) begin
                            squash <= 1'b0;
                            state  <= resume;
                        end else begin
                            inst_out <= fetch_inst;
                            inst_pc  <= pc;
                            pc       <= pc + PC_STEP;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // A redirect kills the held instruction without counting it.
                    if (redirect_valid) begin
                        state <= resume;
                    end else if (inst_ready) begin
                        fetch_count <= fetch_count + 1'b1;
                        state       <= resume;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
